// File: rtl/ram_line_master_pkg.sv
// Shared encodings and geometry for the cache-side line RAM controller.
package cache_mem_pkg;

   localparam int LINE_W     = 128;
   localparam int LINE_OFF_W = 4;
   localparam int RAM_IDX_W  = 9;

   localparam logic [1:0] MTYPE_LINE = 2'b11;
   localparam logic [1:0] MTYPE_NONE = 2'b00;

   typedef enum logic [1:0] {
      OP_READ  = 2'b00,
      OP_WRITE = 2'b01,
      OP_SWAP  = 2'b10,
      OP_RSVD  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACCESS,
      ST_RESP
   } state_e;

   typedef enum logic {
      PH_WR,
      PH_RD
   } phase_e;

   // Bit 31 is a don't-care alias; anything set in [30:9] falls outside the 512-byte array.
   function automatic logic in_range(input logic [31:0] a);
      return a[30:RAM_IDX_W] == '0;
   endfunction

endpackage

// File: rtl/ram_line_master_if.sv
// Cache-side request/response handshake for the line RAM controller.
interface ram_line_master_if #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 128
);
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_op;
   logic [ADDR_W-1:0] req_addr;
   logic [ADDR_W-1:0] req_wb_addr;
   logic [LINE_W-1:0] req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [LINE_W-1:0] resp_rdata;
   logic              resp_err;

   modport master (
      output req_valid, req_op, req_addr, req_wb_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_wb_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/ram_line_master_timer.sv
// Loadable down-counter with zero flag; reloaded for each wait phase of a request.
module mem_lat_timer #(
   parameter int W = 4
) (
   input  logic         clka,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);
   logic [W-1:0] cnt;

   always_ff @(posedge clka or posedge rst) begin
      if (rst)                    cnt <= '0;
      else if (load)              cnt <= load_val;
      else if (dec && cnt != '0)  cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);
endmodule

// File: rtl/ram_line_master.sv
// Line RAM initiator: holds each read/write/swap request for LATENCY cycles per
// access phase, drives the RAM port for one cycle, then returns the line.
module ram_line_master #(
   parameter int LATENCY = 4,
   parameter int ADDR_W  = 32,
   parameter int LINE_W  = cache_mem_pkg::LINE_W
) (
   input  logic              clka,
   input  logic              rst,
   ram_line_master_if.slave  bus,
   output logic [ADDR_W-1:0] addra,
   output logic [LINE_W-1:0] dina,
   output logic              wea,
   input  logic [LINE_W-1:0] douta,
   output logic [1:0]        mtype
);
   import cache_mem_pkg::*;

   localparam int         CNT_W  = 4;
   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   state_e            state, state_n;
   phase_e            phase;
   op_e               op_q;
   logic [ADDR_W-1:0] addr_q, wb_q, cur_addr;
   logic [LINE_W-1:0] wdata_q, rdata_q;
   logic              err_q;
   logic              cur_ok;
   logic              cnt_load, cnt_dec, cnt_zero;

   mem_lat_timer #(.W(CNT_W)) u_timer (
      .clka     (clka),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (LAT_M1),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   assign cur_addr = (phase == PH_WR) ? wb_q : addr_q;
   assign cur_ok   = in_range(cur_addr[31:0]);

   always_comb begin
      state_n  = state;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      unique case (state)
         ST_IDLE: if (bus.req_valid) begin
            state_n  = ST_WAIT;
            cnt_load = 1'b1;
         end
         ST_WAIT: begin
            if (cnt_zero) state_n = ST_ACCESS;
            else          cnt_dec = 1'b1;
         end
         ST_ACCESS: begin
            // Swap turns around after the writeback and waits again for the refill.
            if (phase == PH_WR && op_q == OP_SWAP) begin
               state_n  = ST_WAIT;
               cnt_load = 1'b1;
            end else begin
               state_n  = ST_RESP;
            end
         end
         ST_RESP: if (bus.resp_ready) state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clka or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         phase   <= PH_RD;
         op_q    <= OP_READ;
         addr_q  <= '0;
         wb_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state <= state_n;
         if (state == ST_IDLE && bus.req_valid) begin
            op_q    <= op_e'(bus.req_op);
            addr_q  <= {bus.req_addr[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
            wb_q    <= {bus.req_wb_addr[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
            wdata_q <= bus.req_wdata;
            err_q   <= 1'b0;
            phase   <= (bus.req_op == OP_WRITE || bus.req_op == OP_SWAP) ? PH_WR : PH_RD;
         end
         if (state == ST_ACCESS) begin
            if (!cur_ok) err_q <= 1'b1;
            if (phase == PH_WR) begin
               if (op_q == OP_SWAP) phase   <= PH_RD;
               else                 rdata_q <= '0;
            end else begin
               rdata_q <= cur_ok ? douta : '0;
            end
         end
      end
   end

   assign addra = cur_addr;
   assign dina  = wdata_q;
   assign wea   = (state == ST_ACCESS) && (phase == PH_WR) && cur_ok;
   assign mtype = (state == ST_ACCESS) ? MTYPE_LINE : MTYPE_NONE;

   assign bus.req_ready  = (state == ST_IDLE);
   assign bus.resp_valid = (state == ST_RESP);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_ram_line_master.sv
// Directed bench for ram_line_master with a 512-byte line RAM model (byte i = i at start).
module tb_ram_line_master;
   localparam int LAT = 4;

   logic         clka = 1'b0;
   logic         rst;
   logic [31:0]  addra;
   logic [127:0] dina, douta;
   logic         wea;
   logic [1:0]   mtype;
   logic         init_req;

   ram_line_master_if #(.ADDR_W(32), .LINE_W(128)) bus ();

   ram_line_master #(.LATENCY(LAT), .ADDR_W(32), .LINE_W(128)) dut (
      .clka  (clka),
      .rst   (rst),
      .bus   (bus),
      .addra (addra),
      .dina  (dina),
      .wea   (wea),
      .douta (douta),
      .mtype (mtype)
   );

   always #5 clka = ~clka;

   function automatic logic [127:0] pat(input int k);
      logic [127:0] p;
      for (int j = 0; j < 16; j++) p[8*j +: 8] = 8'(16*k + j);
      return p;
   endfunction

   logic [127:0] mem [32];
   assign douta = mem[addra[8:4]];

   always @(posedge clka) begin
      if (init_req) for (int k = 0; k < 32; k++) mem[k] <= pat(k);
      else if (wea) mem[addra[8:4]] <= dina;
   end

   // wea pulse monitor, sampled mid-cycle
   int          wea_n = 0;
   logic [31:0] wea_addr = '0;
   logic [1:0]  wea_mtype = '0;
   always @(negedge clka) begin
      if (wea) begin
         wea_n     <= wea_n + 1;
         wea_addr  <= addra;
         wea_mtype <= mtype;
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // Returns just after the accept edge with req_valid dropped.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] wb,
                        input logic [127:0] wd);
      @(negedge clka);
      bus.req_valid   = 1'b1;
      bus.req_op      = op;
      bus.req_addr    = a;
      bus.req_wb_addr = wb;
      bus.req_wdata   = wd;
      @(posedge clka);
      #1 bus.req_valid = 1'b0;
   endtask

   // Cycle 1 is the cycle right after the accept edge; lat = 0 means no response seen.
   task automatic wait_resp(output int lat);
      lat = 0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clka);
         if (bus.resp_valid) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic complete();
      bus.resp_ready = 1'b1;
      @(posedge clka);
      #1 bus.resp_ready = 1'b0;
   endtask

   typedef struct {
      logic [1:0]   op;
      logic [31:0]  addr;
      logic [31:0]  wb;
      logic [127:0] wdata;
      logic [127:0] exp_rdata;
      logic         exp_err;
      int           exp_lat;
      int           exp_wn;
      logic [31:0]  exp_waddr;
   } vec_t;

   localparam logic [127:0] DW = 128'hDEADBEEF_00112233_44556677_8899AABB;
   localparam logic [127:0] DA = 128'hA5A5A5A5_5A5A5A5A_01234567_89ABCDEF;
   localparam logic [127:0] DX = 128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC;
   localparam logic [127:0] DB = 128'h0BADF00D_CAFEBABE_13579BDF_2468ACE0;

   vec_t vt [11];

   initial begin
      int           lat, w0, seen;
      logic [127:0] rd, hold_rd;
      logic         er, hold_er;

      vt[0]  = '{2'b00, 32'h20,       32'h0,   '0, 128'h2F2E2D2C2B2A29282726252423222120, 1'b0, 6,  0, 32'h0};
      vt[1]  = '{2'b01, 32'h0,        32'h40,  DW, '0,                                    1'b0, 6,  1, 32'h40};
      vt[2]  = '{2'b00, 32'h40,       32'h0,   '0, DW,                                    1'b0, 6,  0, 32'h0};
      vt[3]  = '{2'b10, 32'h80,       32'h60,  DA, 128'h8F8E8D8C8B8A89888786858483828180, 1'b0, 11, 1, 32'h60};
      vt[4]  = '{2'b00, 32'h60,       32'h0,   '0, DA,                                    1'b0, 6,  0, 32'h0};
      vt[5]  = '{2'b01, 32'h0,        32'h400, DX, '0,                                    1'b1, 6,  0, 32'h0};
      vt[6]  = '{2'b00, 32'h400,      32'h0,   '0, '0,                                    1'b1, 6,  0, 32'h0};
      vt[7]  = '{2'b00, 32'h23,       32'h0,   '0, 128'h2F2E2D2C2B2A29282726252423222120, 1'b0, 6,  0, 32'h0};
      vt[8]  = '{2'b00, 32'h8000_0020, 32'h0,  '0, 128'h2F2E2D2C2B2A29282726252423222120, 1'b0, 6,  0, 32'h0};
      vt[9]  = '{2'b10, 32'h30,       32'h400, DX, 128'h3F3E3D3C3B3A39383736353433323130, 1'b1, 11, 0, 32'h0};
      vt[10] = '{2'b11, 32'h50,       32'h0,   '0, 128'h5F5E5D5C5B5A59585756555453525150, 1'b0, 6,  0, 32'h0};

      rst = 1'b1; init_req = 1'b1;
      bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_addr = '0;
      bus.req_wb_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b0;
      repeat (2) @(negedge clka);
      init_req = 1'b0;

      chki("rst req_ready", int'(bus.req_ready), 1);
      chki("rst resp_valid", int'(bus.resp_valid), 0);
      chki("rst wea", int'(wea), 0);
      chki("rst mtype", int'(mtype), 0);
      chk("rst addra", 128'(addra), '0);
      chk("rst dina", dina, '0);
      chk("rst resp_rdata", bus.resp_rdata, '0);
      chki("rst resp_err", int'(bus.resp_err), 0);
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         w0 = wea_n;
         issue(vt[i].op, vt[i].addr, vt[i].wb, vt[i].wdata);
         wait_resp(lat);
         rd = bus.resp_rdata;
         er = bus.resp_err;
         if (lat != 0) complete();
         @(negedge clka);
         chki($sformatf("v%0d latency", i), lat, vt[i].exp_lat);
         chk($sformatf("v%0d rdata", i), rd, vt[i].exp_rdata);
         chki($sformatf("v%0d err", i), int'(er), int'(vt[i].exp_err));
         chki($sformatf("v%0d wea pulses", i), wea_n - w0, vt[i].exp_wn);
         if (vt[i].exp_wn > 0) begin
            chk($sformatf("v%0d wea addra", i), 128'(wea_addr), 128'(vt[i].exp_waddr));
            chki($sformatf("v%0d wea mtype", i), int'(wea_mtype), 3);
         end
      end
      chk("ram line 0x60", mem[6], DA);
      chk("ram line 0x40", mem[4], DW);

      // Unaligned address is line-aligned on the RAM port during WAIT.
      issue(2'b00, 32'h23, 32'h0, '0);
      @(negedge clka);
      chk("unaligned addra", 128'(addra), 128'h20);
      chki("wait mtype", int'(mtype), 0);
      wait_resp(lat);
      if (lat != 0) complete();

      // Backpressure: response held stable with resp_ready low.
      issue(2'b00, 32'h50, 32'h0, '0);
      wait_resp(lat);
      chki("bp resp seen", int'(lat != 0), 1);
      hold_rd = bus.resp_rdata;
      hold_er = bus.resp_err;
      chk("bp rdata", hold_rd, 128'h5F5E5D5C5B5A59585756555453525150);
      for (int c = 0; c < 5; c++) begin
         @(negedge clka);
         chki("bp resp_valid", int'(bus.resp_valid), 1);
         chk("bp rdata stable", bus.resp_rdata, hold_rd);
         chki("bp err stable", int'(bus.resp_err), int'(hold_er));
         chki("bp req_ready", int'(bus.req_ready), 0);
      end
      complete();
      @(negedge clka);
      chki("bp idle req_ready", int'(bus.req_ready), 1);
      chki("bp idle resp_valid", int'(bus.resp_valid), 0);

      // Reset while the write access is on the port: wea drops without a clock edge.
      issue(2'b01, 32'h0, 32'h100, DX);
      repeat (5) @(negedge clka);
      chki("acc wea before rst", int'(wea), 1);
      rst = 1'b1;
      #1;
      chki("acc wea after rst", int'(wea), 0);
      chki("acc req_ready in rst", int'(bus.req_ready), 1);
      repeat (2) @(negedge clka);
      rst = 1'b0;
      chk("acc ram untouched", mem[16], pat(16));

      // Reset during the second WAIT of a swap: writeback done, refill dropped.
      w0 = wea_n;
      issue(2'b10, 32'h90, 32'h70, DB);
      repeat (7) @(negedge clka);
      rst = 1'b1;
      #1;
      chki("swap rst wea", int'(wea), 0);
      chki("swap rst resp_valid", int'(bus.resp_valid), 0);
      repeat (2) @(negedge clka);
      rst = 1'b0;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clka);
         if (bus.resp_valid) seen++;
      end
      chki("swap rst no resp", seen, 0);
      chki("swap rst req_ready", int'(bus.req_ready), 1);
      chki("swap rst wea pulses", wea_n - w0, 1);
      chk("swap rst wb line", mem[7], DB);
      chk("swap rst rd line", mem[9], pat(9));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/ram_line_master.md
Name: ram_line_master

Overview:
- Initiator-side controller for the 128-bit line RAM (512-byte array, combinational read, write on clock edge).
- Accepts line requests from the cache over a valid/ready handshake: read (refill), write (writeback), or swap (victim writeback then refill).
- Holds each request for a programmable memory latency, then drives the RAM port and returns line data.
- Sits between the cache/prefetcher and the line RAM.

Parameters:
- LATENCY, 4, wait cycles before each RAM access phase; legal range 1..15.
- ADDR_W, 32, byte address width.
- LINE_W, 128, line width in bits.

Ports:
- clka  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_op  in  2  00 read, 01 write, 10 swap, 11 reserved (treated as read)
- req_addr  in  ADDR_W  read/refill line address
- req_wb_addr  in  ADDR_W  writeback address (write and swap)
- req_wdata  in  LINE_W  writeback line
- resp_valid  out  1  response present
- resp_ready  in  1  cache accepts response
- resp_rdata  out  LINE_W  refill data; 0 for write op
- resp_err  out  1  an access in this request was out of range
- addra  out  ADDR_W  RAM address
- dina  out  LINE_W  RAM write data
- wea  out  1  RAM write enable
- douta  in  LINE_W  RAM read data
- mtype  out  2  11 during ACCESS, 00 otherwise

Behaviour:
- States: IDLE, WAIT, ACCESS, RESP. Phase register: WR or RD.
- Reset (async): state IDLE, counter 0, resp_rdata 0, resp_err 0, latched address/data 0.
  - Reset output values: wea 0, addra 0, dina 0, mtype 00, resp_valid 0, req_ready 1.
- req_ready = (state==IDLE). resp_valid = (state==RESP).
- IDLE: on req_valid, latch op and addresses with bits [3:0] cleared, latch wdata, clear err, cnt <= LATENCY-1.
  - Phase = WR for write/swap, RD otherwise. Go to WAIT.
- WAIT: addra = current phase address, wea 0. Decrement cnt; at cnt==0 go to ACCESS.
- ACCESS lasts exactly one cycle.
  - Range check: address bits [30:9] must all be zero; bit 31 is ignored.
  - WR phase:
    - dina = wdata; wea = 1 only if in range, else wea 0 and err <= 1.
    - Write op goes to RESP with resp_rdata <= 0.
    - Swap reloads cnt <= LATENCY-1, sets phase = RD, and returns to WAIT.
  - RD phase: resp_rdata <= (in range ? douta : 0); err |= out of range. Go to RESP.
- RESP: hold resp_valid, resp_rdata, and resp_err stable until resp_ready; on the handshake go to IDLE.
  - Back-to-back: the next request is accepted no earlier than the cycle after the response handshake.
- addra, dina, wea, and mtype are combinational from state/latched registers and are stable throughout ACCESS.
- Latency from the accept edge to the first resp_valid cycle:
  - read/write: LATENCY+2
  - swap: 2*LATENCY+3
- resp_ready held high while already in RESP completes in one cycle.
- Reset during WAIT or ACCESS: immediately returns to IDLE, wea drops asynchronously, the request is dropped, and no response is issued.
- req_valid while busy: ignored; the requester holds it per handshake rules.

Decomposition:
- Package cache_mem_pkg:
  - op encodings OP_READ, OP_WRITE, OP_SWAP
  - state enum
  - LINE_W, LINE_OFF_W=4, RAM_IDX_W=9
  - MTYPE_LINE=2'b11
- Optional sub-module mem_lat_timer: loadable down-counter with a zero flag, reused for both swap phases.
- Everything else stays in a single module.

Test Plan:
- Read: LATENCY=4, RAM preloaded with byte i = i, read addr 0x20.
  - Expect resp_valid exactly 6 cycles after accept, resp_rdata = 0x2F2E...2120, err 0, wea never high.
- Write then read back: write 0x40 with data 0xDEADBEEF_00112233_44556677_8899AABB.
  - Expect a single wea pulse with addra 0x40 and mtype 11.
  - A following read of 0x40 returns the same data.
- Swap: wb_addr 0x60 with data A, addr 0x80.
  - Expect wea at cycle 5 with addra 0x60, then the RD access with addra 0x80; resp at cycle 11.
  - Expect rdata = RAM[0x80..0x8F], and RAM[0x60..] = A.
- Out of range: write to 0x400 -> wea stays 0, resp_err 1.
  - Read of 0x400 -> rdata 0, err 1.
  - Unaligned read 0x23 -> addra 0x20.
- Backpressure: resp_ready held low for 5 cycles.
  - Expect resp_valid, rdata, and err stable; req_ready 0 throughout; IDLE the cycle after resp_ready rises.
- Reset mid-swap: assert rst during the second WAIT.
  - Expect wea 0 immediately, no resp_valid, req_ready 1 after release.
  - Expect RAM to contain the completed writeback only.
